// File: rtl/lsu_ctrl.sv
// Load/store initiator: takes one RISC-V load/store, drives the memory port for a
// single strobe cycle, waits LATENCY cycles, then returns an extended result or error.
module lsu_ctrl #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_waddr,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [2:0]  mem_rsize,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [3:0]  cnt_q;

  logic        accept;
  logic        req_bad;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [3:0]  mask4;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    req_bad = 1'b0;
    case (req_func3)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = req_addr[0];
      3'b010:         req_bad = |req_addr[1:0];
      default:        req_bad = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = req_bad ? RESP : ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (cnt_q == 4'd1) state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load lane selection and extension, keyed on the latched width code.
  always_comb begin
    lane     = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = lane;
    case (func3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          wen_q   <= req_wen;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          func3_q <= req_func3;
          err_q   <= req_bad;
          rdata_q <= '0;
        end
        ISSUE: cnt_q <= LAT;
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1 && !wen_q) rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (func3_q[1:0])
      2'b00:   mask4 = 4'b0001;
      2'b01:   mask4 = 4'b0011;
      default: mask4 = 4'b1111;
    endcase
    mask4 = mask4 << addr_q[1:0];
  end

  // Output logic: memory port is live only in ISSUE, response only in RESP.
  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    resp_valid = (state == RESP);
    resp_rdata = (state == RESP) ? rdata_q : 32'd0;
    resp_err   = (state == RESP) && err_q;
    mem_waddr  = '0;
    mem_wmask  = '0;
    mem_wdata  = '0;
    mem_wen    = 1'b0;
    mem_raddr  = '0;
    mem_rsize  = '0;
    mem_ren    = 1'b0;
    if (state == ISSUE) begin
      if (wen_q) begin
        mem_wen   = 1'b1;
        mem_waddr = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
        mem_wmask = {4'b0000, mask4};
      end else begin
        mem_ren   = 1'b1;
        mem_raddr = {addr_q[31:2], 2'b00};
        mem_rsize = 3'd4;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one instance at LATENCY=1 and one at LATENCY=4 share
// the stimulus; each scenario checks the instance whose timing it exercises.
module tb_lsu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        resp_ready;
  logic [31:0] mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_wen, a_mem_ren;
  logic [31:0] a_resp_rdata, a_mem_waddr, a_mem_wdata, a_mem_raddr;
  logic [7:0]  a_mem_wmask;
  logic [2:0]  a_mem_rsize;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_wen, b_mem_ren;
  logic [31:0] b_resp_rdata, b_mem_waddr, b_mem_wdata, b_mem_raddr;
  logic [7:0]  b_mem_wmask;
  logic [2:0]  b_mem_rsize;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .mem_waddr(a_mem_waddr), .mem_wmask(a_mem_wmask),
    .mem_wdata(a_mem_wdata), .mem_wen(a_mem_wen), .mem_raddr(a_mem_raddr),
    .mem_rsize(a_mem_rsize), .mem_ren(a_mem_ren), .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.LATENCY(4)) dut4 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .mem_waddr(b_mem_waddr), .mem_wmask(b_mem_wmask),
    .mem_wdata(b_mem_wdata), .mem_wen(b_mem_wen), .mem_raddr(b_mem_raddr),
    .mem_rsize(b_mem_rsize), .mem_ren(b_mem_ren), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_func3 = f3;
  endtask

  task automatic test_reset();
    smp();
    checks++;
    if ({a_req_ready, a_resp_valid, a_resp_err, a_resp_rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_resp: got rdy=%b v=%b err=%b rdata=%h, want all 0",
               a_req_ready, a_resp_valid, a_resp_err, a_resp_rdata);
    end
    checks++;
    if ({a_mem_wen, a_mem_ren, a_mem_waddr, a_mem_wmask, a_mem_wdata, a_mem_raddr, a_mem_rsize} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got wen=%b ren=%b waddr=%h wmask=%h, want all 0",
               a_mem_wen, a_mem_ren, a_mem_waddr, a_mem_wmask);
    end
    cyc();
    reset = 1'b0;
    smp();
    checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", a_req_ready, b_req_ready);
    end
    cyc();
  endtask

  task automatic test_store_byte();
    drive_req(1'b1, 32'h8000_0003, 32'h0000_00AB, 3'b000);
    smp();
    checks++;
    if (a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_ready: got %b want 1", a_req_ready);
    end
    cyc();
    req_valid = 1'b0;
    smp();
    checks++;
    if (a_mem_wen !== 1'b1 || a_mem_ren !== 1'b0 || a_mem_waddr !== 32'h8000_0000 ||
        a_mem_wmask !== 8'h08 || a_mem_wdata !== 32'hAB00_0000) begin
      errors++;
      $display("FAIL sb_issue: got wen=%b ren=%b waddr=%h wmask=%h wdata=%h, want 1 0 80000000 08 ab000000",
               a_mem_wen, a_mem_ren, a_mem_waddr, a_mem_wmask, a_mem_wdata);
    end
    cyc();
    smp();
    checks++;
    if (a_mem_wen !== 1'b0 || a_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sb_wait: got wen=%b resp_valid=%b, want 0 0", a_mem_wen, a_resp_valid);
    end
    cyc();
    smp();
    checks++;
    if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0 || a_resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL sb_resp: got v=%b err=%b rdata=%h, want 1 0 0",
               a_resp_valid, a_resp_err, a_resp_rdata);
    end
    cyc();
    smp();
    checks++;
    if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sb_return: got rdy=%b v=%b, want 1 0", a_req_ready, a_resp_valid);
    end
    idle(8);
  endtask

  task automatic test_byte_loads();
    logic [31:0] addrs [5] = '{32'h2001, 32'h2002, 32'h2003, 32'h2002, 32'h2000};
    logic [2:0]  f3s   [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                               32'hFFFF_80FF, 32'h0000_7F01};
    mem_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, addrs[i], 32'h0, f3s[i]);
      cyc();
      req_valid = 1'b0;
      smp();
      checks++;
      if (a_mem_ren !== 1'b1 || a_mem_raddr !== 32'h2000 || a_mem_rsize !== 3'd4 || a_mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_issue: got ren=%b raddr=%h rsize=%0d wen=%b, want 1 00002000 4 0",
                 i, a_mem_ren, a_mem_raddr, a_mem_rsize, a_mem_wen);
      end
      idle(2);
      smp();
      checks++;
      if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0 || a_resp_rdata !== exps[i]) begin
        errors++;
        $display("FAIL load%0d_data: got v=%b err=%b rdata=%h, want 1 0 %h",
                 i, a_resp_valid, a_resp_err, a_resp_rdata, exps[i]);
      end
      idle(8);
    end
  endtask

  task automatic test_errors();
    logic        wens  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] addrs [3] = '{32'h1002, 32'h1001, 32'h1000};
    logic [2:0]  f3s   [3] = '{3'b010, 3'b001, 3'b011};
    logic        pulse;
    for (int i = 0; i < 3; i++) begin
      drive_req(wens[i], addrs[i], 32'hFFFF_FFFF, f3s[i]);
      cyc();
      req_valid = 1'b0;
      smp();
      checks++;
      if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b1 || a_resp_rdata !== 32'd0 ||
          b_resp_valid !== 1'b1 || b_resp_err !== 1'b1) begin
        errors++;
        $display("FAIL err%0d_resp: got v=%b err=%b rdata=%h (lat4 v=%b err=%b), want 1 1 0",
                 i, a_resp_valid, a_resp_err, a_resp_rdata, b_resp_valid, b_resp_err);
      end
      pulse = a_mem_ren | a_mem_wen | b_mem_ren | b_mem_wen;
      for (int k = 0; k < 4; k++) begin
        cyc();
        smp();
        pulse = pulse | a_mem_ren | a_mem_wen | b_mem_ren | b_mem_wen;
      end
      checks++;
      if (pulse !== 1'b0) begin
        errors++;
        $display("FAIL err%0d_no_strobe: got strobe=%b want 0", i, pulse);
      end
      cyc();
    end
  endtask

  task automatic test_latency();
    mem_rdata = 32'h1111_1111;
    drive_req(1'b0, 32'h3000, 32'h0, 3'b010);
    cyc();
    req_valid = 1'b0;
    smp();
    checks++;
    if (b_mem_ren !== 1'b1 || b_mem_raddr !== 32'h3000 || b_mem_rsize !== 3'd4) begin
      errors++;
      $display("FAIL lat_issue: got ren=%b raddr=%h rsize=%0d, want 1 00003000 4",
               b_mem_ren, b_mem_raddr, b_mem_rsize);
    end
    cyc(); mem_rdata = 32'h2222_2222;
    cyc(); mem_rdata = 32'h3333_3333;
    cyc(); mem_rdata = 32'h4444_4444;
    cyc(); mem_rdata = 32'hCAFE_BABE;
    smp();
    checks++;
    if (b_resp_valid !== 1'b0 || b_mem_ren !== 1'b0) begin
      errors++;
      $display("FAIL lat_early: got v=%b ren=%b at A+5, want 0 0", b_resp_valid, b_mem_ren);
    end
    cyc(); mem_rdata = 32'hDEAD_DEAD;
    smp();
    checks++;
    if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b0 || b_resp_rdata !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL lat_resp: got v=%b err=%b rdata=%h, want 1 0 cafebabe",
               b_resp_valid, b_resp_err, b_resp_rdata);
    end
    idle(6);
  endtask

  task automatic test_backpressure();
    mem_rdata  = 32'h1234_5678;
    resp_ready = 1'b0;
    drive_req(1'b0, 32'h4000, 32'h0, 3'b010);
    cyc();
    req_valid = 1'b0;
    idle(2);
    for (int i = 0; i < 5; i++) begin
      smp();
      checks++;
      if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h1234_5678 || a_resp_err !== 1'b0 ||
          a_req_ready !== 1'b0 || a_mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b rdata=%h err=%b rdy=%b wen=%b, want 1 12345678 0 0 0",
                 i, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready, a_mem_wen);
      end
      if (i == 0) drive_req(1'b1, 32'h5000, 32'h0000_0BAD, 3'b010);
      cyc();
    end
    resp_ready = 1'b1;
    smp();
    checks++;
    if (a_resp_valid !== 1'b1 || a_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b, want 1 0", a_resp_valid, a_req_ready);
    end
    cyc();
    req_wdata = 32'h0000_0055;
    smp();
    checks++;
    if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_back: got rdy=%b v=%b, want 1 0", a_req_ready, a_resp_valid);
    end
    cyc();
    req_valid = 1'b0;
    smp();
    checks++;
    if (a_mem_wen !== 1'b1 || a_mem_waddr !== 32'h5000 || a_mem_wdata !== 32'h55 || a_mem_wmask !== 8'h0F) begin
      errors++;
      $display("FAIL bp_next_issue: got wen=%b waddr=%h wdata=%h wmask=%h, want 1 00005000 00000055 0f",
               a_mem_wen, a_mem_waddr, a_mem_wdata, a_mem_wmask);
    end
    idle(10);
  endtask

  task automatic test_mid_reset();
    logic seen;
    drive_req(1'b0, 32'h7000, 32'h0, 3'b010);
    cyc();
    req_valid = 1'b0;
    idle(2);
    reset = 1'b1;
    smp();
    checks++;
    if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0 || b_mem_ren !== 1'b0 ||
        b_resp_rdata !== 32'd0 || b_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got v=%b rdy=%b ren=%b rdata=%h err=%b, want all 0",
               b_resp_valid, b_req_ready, b_mem_ren, b_resp_rdata, b_resp_err);
    end
    idle(2);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp();
      seen = seen | b_resp_valid | b_mem_ren | b_mem_wen;
      cyc();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resp: got activity=%b after reset, want 0", seen);
    end
    drive_req(1'b1, 32'h6004, 32'h0000_0007, 3'b010);
    cyc();
    req_valid = 1'b0;
    smp();
    checks++;
    if (b_mem_wen !== 1'b1 || b_mem_waddr !== 32'h6004 || b_mem_wmask !== 8'h0F || b_mem_wdata !== 32'h7) begin
      errors++;
      $display("FAIL rst_sw_issue: got wen=%b waddr=%h wmask=%h wdata=%h, want 1 00006004 0f 00000007",
               b_mem_wen, b_mem_waddr, b_mem_wmask, b_mem_wdata);
    end
    idle(5);
    smp();
    checks++;
    if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b0 || b_resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_sw_resp: got v=%b err=%b rdata=%h, want 1 0 0",
               b_resp_valid, b_resp_err, b_resp_rdata);
    end
    idle(4);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_func3  = '0;
    resp_ready = 1'b1;
    mem_rdata  = '0;
    test_reset();
    test_store_byte();
    test_byte_loads();
    test_errors();
    test_latency();
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator between the NPC execute stage and the `Memory` block. It accepts one RISC-V load or store request at a time through a valid/ready handshake and formats it into the memory port signals (`waddr`/`wmask`/`wdata`/`wen`, `raddr`/`rsize`/`ren`). It waits a fixed memory latency, then extracts and extends the read data and returns a response through a second valid/ready handshake. Misaligned and illegal-width requests are answered with an error and never reach memory.

## Interface
- `LATENCY`, default 1: cycles from the memory strobe cycle to `mem_rdata` being valid. Legal range 1..15.

- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_func3` in 3: width code. 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu; other codes are illegal.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: load result, extended; 0 for stores and errors.
- `resp_err` out 1: request was misaligned or illegal.
- `mem_waddr` out 32, `mem_wmask` out 8, `mem_wdata` out 32, `mem_wen` out 1: memory write port.
- `mem_raddr` out 32, `mem_rsize` out 3, `mem_ren` out 1: memory read port.
- `mem_rdata` in 32: memory read word.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Reset puts it in IDLE.
- IDLE:
  - `req_ready`=1 (forced to 0 while `reset` is high).
  - On `req_valid && req_ready`, latch `req_wen`, `req_addr`, `req_wdata` and `req_func3`.
  - A request is an error if `req_func3` is illegal, or if it is a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0.
  - Error request: go to RESP with `err`=1 and data 0. Otherwise go to ISSUE.
- ISSUE, one cycle:
  - Assert `mem_ren` for a load, or `mem_wen` for a store. Never both.
  - Load the latency counter with `LATENCY`, then go to WAIT.
- Store formatting:
  - `mem_waddr` = `{addr[31:2], 2'b00}`.
  - `mem_wdata` = `wdata << (8*addr[1:0])`.
  - `mem_wmask[3:0]` = 0001 (b), 0011 (h) or 1111 (w), shifted left by `addr[1:0]`. `mem_wmask[7:4]`=0.
- Load formatting:
  - `mem_raddr` = `{addr[31:2], 2'b00}`, `mem_rsize`=3'd4.
  - Lane = `mem_rdata >> (8*addr[1:0])`.
  - b/h sign-extend bit 7/15 of the lane; bu/hu zero-extend; w passes the word.
- WAIT:
  - The counter decrements each cycle.
  - When it reaches 1, `mem_rdata` is sampled (loads) at that edge and the FSM goes to RESP.
  - A store returns data 0 and `err`=0.
- RESP: `resp_valid`=1 with `resp_rdata`/`resp_err` held stable. On `resp_ready`, go to IDLE. There is no request bypass in RESP.
- Outside ISSUE, all `mem_*` outputs are 0. The strobes are exactly one cycle wide.
- Only one request is outstanding at a time.

## Timing
- Reset values (asynchronous, while `reset`=1): state IDLE; `req_ready`, `resp_valid`, `resp_err`, `resp_rdata` all 0; all `mem_*` outputs 0; latched registers 0.
- Accept at the edge ending cycle A:
  - ISSUE is cycle A+1.
  - `mem_rdata` is sampled at the edge ending cycle A+1+`LATENCY`.
  - `resp_valid` is first high in cycle A+2+`LATENCY`.
- Error path: `resp_valid` is high in cycle A+1.
- When `resp_ready` is held high: `req_ready` returns in the cycle after the response handshake. Back-to-back throughput is one request per `LATENCY`+3 cycles.
- Reset asserted mid-operation (any state, including the ISSUE strobe cycle):
  - Immediate return to IDLE with the reset values above.
  - Any pending response is discarded and no further memory strobe is issued.
- `req_valid` while not in IDLE is ignored and not latched.
- While `resp_valid`=1 and `resp_ready`=0, outputs hold for any number of cycles.

## Test plan
- **Store byte.** `LATENCY`=1; store sb, addr 0x8000_0003, wdata 0x0000_00AB.
  - Required: one-cycle `mem_wen`, `mem_waddr`=0x8000_0000, `mem_wmask`=0x08, `mem_wdata`=0xAB00_0000.
  - Response with `err`=0 in cycle A+3.
- **Signed/unsigned byte loads.** `mem_rdata`=0x80FF_7F01.
  - lb @+1 → 0x0000_007F.
  - lb @+2 → 0xFFFF_FFFF.
  - lbu @+3 → 0x0000_0080.
  - lh @+2 → 0xFFFF_80FF.
  - lhu @+0 → 0x0000_7F01.
- **Misaligned and illegal requests.**
  - lw @0x1002 → `resp_err`=1, `rdata`=0, `resp_valid` in cycle A+1, no `mem_ren`/`mem_wen` pulse.
  - sh @0x1001 → same error response.
  - `func3`=3'b011 → same error response.
- **Latency parameter.** `LATENCY`=4; load word.
  - `mem_ren` in cycle A+1.
  - `mem_rdata` changed before the sample edge is ignored; the value present at the edge ending A+5 is returned.
  - `resp_valid` in cycle A+6.
- **Backpressure.** Hold `resp_ready`=0 for 5 cycles.
  - Response stays stable; `req_ready` stays 0; a `req_valid` during this time is not accepted.
  - After `resp_ready`=1, the next request is accepted one cycle later.
- **Mid-operation reset.** Assert `reset` during WAIT (`LATENCY`=4).
  - Outputs go to 0 immediately; no response appears.
  - After release, a new sw completes normally.
